scope_capture_ctrl: RTL

- Sequences one scope acquisition: arm, fill pre-trigger history, detect trigger, capture post-trigger samples into an internal circular buffer, then stream the frame byte-by-byte to the UART transmitter.
- Sits between the downsampling stage (sample/valid stream) and uart_tx (DV/Active/Done handshake).
- Replaces free-running per-sample UART transmission with triggered, gap-free frames.

---
 rtl/scope_capture_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/scope_capture_ctrl.sv
// Triggered scope acquisition: pre-trigger history, trigger detect, post capture, UART frame streaming.
// Optional build macro SCOPE_FRAME_HEADER_EN prepends the 3-byte header 0xA5, 0x5A, pPreTrig[7:0].
module scope_capture_ctrl #(
    parameter int pAddrBits = 9,
    parameter int pPreTrig  = 128
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iArm,
    input  logic       iForce,
    input  logic [7:0] iTrigLevel,
    input  logic       iTrigFalling,
    input  logic [7:0] iData,
    input  logic       iData_Valid,
    output logic       oTx_DV,
    output logic [7:0] oTx_Byte,
    input  logic       iTx_Active,
    input  logic       iTx_Done,
    output logic       oBusy,
    output logic       oTriggered,
    output logic [2:0] oState
);

    localparam int N = 1 << pAddrBits;
`ifdef SCOPE_FRAME_HEADER_EN
    localparam int HdrLen = 3;
`else
    localparam int HdrLen = 0;
`endif
    localparam int FrameLen = N + HdrLen;
    localparam int CntW     = pAddrBits + 2;

    localparam logic [pAddrBits-1:0] PTR_ONE    = pAddrBits'(1);
    localparam logic [pAddrBits-1:0] PRE_LAST   = pAddrBits'(pPreTrig - 1);
    localparam logic [pAddrBits-1:0] PRE_OFFS   = pAddrBits'(pPreTrig);
    localparam logic [pAddrBits-1:0] POST_LOAD  = pAddrBits'(N - pPreTrig - 1);
    localparam logic [CntW-1:0]      CNT_ONE    = CntW'(1);
    localparam logic [CntW-1:0]      FRAME_LAST = CntW'(FrameLen - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        READ      = 3'd4,
        SEND      = 3'd5,
        WAIT_DONE = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [7:0]             mem_r [0:N-1];
    logic [7:0]             rd_data_r;
    logic [pAddrBits-1:0]   wr_ptr_r;
    logic [pAddrBits-1:0]   pre_cnt_r;
    logic [pAddrBits-1:0]   post_cnt_r;
    logic [pAddrBits-1:0]   raddr_r;
    logic [CntW-1:0]        byte_cnt_r;
    logic [7:0]             prev_sample_r;
    logic                   prev_valid_r;
    logic                   force_pend_r;
    logic                   triggered_r;
    logic                   tx_dv_r;
    logic [7:0]             tx_byte_r;

    logic                   wr_en_s;
    logic                   edge_hit_s;
    logic                   trig_s;
    logic                   send_s;
    logic                   done_s;
    logic                   last_byte_s;
    logic                   adv_raddr_s;
    logic [7:0]             tx_byte_s;

    // Datapath strobes, trigger evaluation and outgoing byte selection
    always_comb begin
        wr_en_s     = 1'b0;
        edge_hit_s  = 1'b0;
        trig_s      = 1'b0;
        send_s      = 1'b0;
        done_s      = 1'b0;
        last_byte_s = 1'b0;
        adv_raddr_s = 1'b0;
        tx_byte_s   = rd_data_r;

        if ((state_r == PRE) || (state_r == WAIT_TRIG) || (state_r == POST)) begin
            wr_en_s = iData_Valid;
        end else begin
            wr_en_s = 1'b0;
        end

        if (iTrigFalling) begin
            edge_hit_s = (prev_sample_r > iTrigLevel) && (iData <= iTrigLevel);
        end else begin
            edge_hit_s = (prev_sample_r < iTrigLevel) && (iData >= iTrigLevel);
        end

        if ((state_r == WAIT_TRIG) && iData_Valid) begin
            trig_s = force_pend_r || iForce || (prev_valid_r && edge_hit_s);
        end else begin
            trig_s = 1'b0;
        end

        send_s      = (state_r == SEND) && !iTx_Active;
        done_s      = (state_r == WAIT_DONE) && iTx_Done;
        last_byte_s = (byte_cnt_r == FRAME_LAST);

`ifdef SCOPE_FRAME_HEADER_EN
        // Header bytes are sent without consuming buffer addresses
        adv_raddr_s = (byte_cnt_r >= CntW'(HdrLen));
        case (byte_cnt_r)
            CntW'(0): tx_byte_s = 8'hA5;
            CntW'(1): tx_byte_s = 8'h5A;
            CntW'(2): tx_byte_s = 8'(pPreTrig);
            default:  tx_byte_s = rd_data_r;
        endcase
`else
        adv_raddr_s = 1'b1;
        tx_byte_s   = rd_data_r;
`endif
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (iArm) next_state_s = PRE;
                else      next_state_s = IDLE;
            end
            PRE: begin
                if (iData_Valid && (pre_cnt_r == PRE_LAST)) next_state_s = WAIT_TRIG;
                else                                        next_state_s = PRE;
            end
            WAIT_TRIG: begin
                if (trig_s) next_state_s = POST;
                else        next_state_s = WAIT_TRIG;
            end
            POST: begin
                if (iData_Valid && (post_cnt_r == PTR_ONE)) next_state_s = READ;
                else                                        next_state_s = POST;
            end
            READ: next_state_s = SEND;
            SEND: begin
                if (send_s) next_state_s = WAIT_DONE;
                else        next_state_s = SEND;
            end
            WAIT_DONE: begin
                if (done_s) begin
                    if (last_byte_s) next_state_s = IDLE;
                    else             next_state_s = READ;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) state_r <= IDLE;
        else      state_r <= next_state_s;
    end

    // Sample buffer: write port plus registered read
    always_ff @(posedge iClk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= iData;
        rd_data_r <= mem_r[raddr_r];
    end

    // Pointers, counters, trigger bookkeeping and UART handshake registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_r      <= '0;
            pre_cnt_r     <= '0;
            post_cnt_r    <= '0;
            raddr_r       <= '0;
            byte_cnt_r    <= '0;
            prev_sample_r <= 8'd0;
            prev_valid_r  <= 1'b0;
            force_pend_r  <= 1'b0;
            triggered_r   <= 1'b0;
            tx_dv_r       <= 1'b0;
            tx_byte_r     <= 8'd0;
        end else begin
            tx_dv_r      <= send_s;
            force_pend_r <= (state_r == WAIT_TRIG) && !trig_s && (force_pend_r || iForce);

            if (send_s) tx_byte_r <= tx_byte_s;

            if ((state_r == IDLE) && iArm) begin
                pre_cnt_r    <= '0;
                prev_valid_r <= 1'b0;
            end

            if (wr_en_s) begin
                wr_ptr_r      <= wr_ptr_r + PTR_ONE;
                prev_sample_r <= iData;
                prev_valid_r  <= 1'b1;
            end

            if ((state_r == PRE) && iData_Valid) pre_cnt_r <= pre_cnt_r + PTR_ONE;

            // Readout starts pPreTrig samples before the trigger sample's address
            if (trig_s) begin
                raddr_r     <= wr_ptr_r - PRE_OFFS;
                post_cnt_r  <= POST_LOAD;
                byte_cnt_r  <= '0;
                triggered_r <= 1'b1;
            end

            if ((state_r == POST) && iData_Valid) post_cnt_r <= post_cnt_r - PTR_ONE;

            if (done_s) begin
                byte_cnt_r <= byte_cnt_r + CNT_ONE;
                if (adv_raddr_s) raddr_r <= raddr_r + PTR_ONE;
                if (last_byte_s) triggered_r <= 1'b0;
            end
        end
    end

    assign oTx_DV     = tx_dv_r;
    assign oTx_Byte   = tx_byte_r;
    assign oTriggered = triggered_r;
    assign oState     = state_r;
    assign oBusy      = (state_r != IDLE);

endmodule
